// File: rtl/pulse_updown_pkg.sv
// ============================================================================
// Module      : pulse_updown_pkg
// Description : Channel state encoding and default timing constants shared
//               by the up/down push-button pulse conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_updown_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_DEB   = 2'd1,
        HELD        = 2'd2,
        RELEASE_DEB = 2'd3
    } chan_state_t;

    localparam int unsigned c_deb_cycles_dflt    = 500000;
    localparam int unsigned c_repeat_delay_dflt  = 25000000;
    localparam int unsigned c_repeat_period_dflt = 10000000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_updown_cond_if.sv
// ============================================================================
// Module      : pulse_updown_cond_if
// Description : Button inputs and increment/decrement pulse outputs of the
//               pulse conditioner; master drives buttons, slave is the block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pulse_updown_cond_if;

    logic btn_up;
    logic btn_down;
    logic aum;
    logic dism;

    modport master (
        output btn_up,
        output btn_down,
        input  aum,
        input  dism
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        output aum,
        output dism
    );

endinterface

`default_nettype wire

// File: rtl/pulse_updown_cond_btn_channel.sv
// ============================================================================
// Module      : btn_channel
// Description : One button: 2-flop synchronizer, press/release debounce FSM
//               and, with AUTO_REPEAT_EN defined, a hold auto-repeat timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_channel
    import pulse_updown_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = c_deb_cycles_dflt,
    parameter int unsigned REPEAT_DELAY  = c_repeat_delay_dflt,
    parameter int unsigned REPEAT_PERIOD = c_repeat_period_dflt
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse,
    output logic held
);

    localparam int unsigned c_deb_w = $clog2(DEB_CYCLES + 1);
    localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_CYCLES - 1);

    if (DEB_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_cfg_err
        $error("btn_channel: DEB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be non-zero");
    end

    logic [1:0]         r_sync;
    logic               w_synced;
    chan_state_t        r_state;
    chan_state_t        w_state_nxt;
    logic [c_deb_w-1:0] r_deb_cnt;
    logic [c_deb_w-1:0] w_deb_cnt_nxt;
    logic               w_press_done;
    logic               r_pulse;

    assign w_synced = r_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], btn};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_deb_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_deb_cnt <= w_deb_cnt_nxt;
        end
    end

    // The counter stops at c_deb_last, so it saturates by construction.
    always_comb begin
        w_state_nxt   = r_state;
        w_deb_cnt_nxt = r_deb_cnt;
        w_press_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_synced) begin
                    w_state_nxt   = PRESS_DEB;
                    w_deb_cnt_nxt = '0;
                end
            end
            PRESS_DEB: begin
                if (!w_synced) begin
                    w_state_nxt   = IDLE;
                    w_deb_cnt_nxt = '0;
                end else if (r_deb_cnt == c_deb_last) begin
                    w_state_nxt   = HELD;
                    w_deb_cnt_nxt = '0;
                    w_press_done  = 1'b1;
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!w_synced) begin
                    w_state_nxt   = RELEASE_DEB;
                    w_deb_cnt_nxt = '0;
                end
            end
            RELEASE_DEB: begin
                if (w_synced) begin
                    w_state_nxt   = HELD;
                    w_deb_cnt_nxt = '0;
                end else if (r_deb_cnt == c_deb_last) begin
                    w_state_nxt   = IDLE;
                    w_deb_cnt_nxt = '0;
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_deb_cnt_nxt = '0;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam int unsigned c_rep_max = max_u(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int unsigned c_rep_w   = $clog2(c_rep_max + 1);

    logic [c_rep_w-1:0] r_rep_cnt;
    logic [c_rep_w-1:0] w_rep_target;
    logic               r_rep_phase;
    logic               w_rep_fire;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; any exit from
    // HELD (including the HELD->RELEASE_DEB edge) restarts the whole schedule.
    assign w_rep_target = r_rep_phase ? c_rep_w'(REPEAT_PERIOD) : c_rep_w'(REPEAT_DELAY);
    assign w_rep_fire   = (r_state == HELD) && w_synced && (r_rep_cnt == w_rep_target);

    always_ff @(posedge clk) begin
        if (reset || (r_state != HELD) || !w_synced) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= c_rep_w'(1);
            r_rep_phase <= 1'b1;
        end else if (r_rep_cnt != c_rep_w'(c_rep_max)) begin
            r_rep_cnt   <= r_rep_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_press_done | w_rep_fire;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_press_done;
        end
    end
`endif

    assign pulse = r_pulse;
    assign held  = (r_state == HELD);

endmodule

`default_nettype wire

// File: rtl/pulse_updown_cond.sv
// ============================================================================
// Module      : pulse_updown_cond
// Description : Up/down button conditioner producing mutually exclusive
//               increment (aum) / decrement (dism) pulses. Define
//               AUTO_REPEAT_EN to enable hold auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_updown_cond
    import pulse_updown_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = c_deb_cycles_dflt,
    parameter int unsigned REPEAT_DELAY  = c_repeat_delay_dflt,
    parameter int unsigned REPEAT_PERIOD = c_repeat_period_dflt
) (
    input  logic                      clk,
    input  logic                      reset,
    pulse_updown_cond_if.slave        bus
);

    logic w_up_pulse;
    logic w_up_held;
    logic w_dn_pulse;
    logic w_dn_held;
    logic w_both_pulse;

    btn_channel #(
        .DEB_CYCLES    (DEB_CYCLES),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_up (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.btn_up),
        .pulse (w_up_pulse),
        .held  (w_up_held)
    );

    btn_channel #(
        .DEB_CYCLES    (DEB_CYCLES),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_down (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.btn_down),
        .pulse (w_dn_pulse),
        .held  (w_dn_held)
    );

    // A pulse is dropped while the opposite button is held, and coincident
    // pulses cancel each other.
    assign w_both_pulse = w_up_pulse & w_dn_pulse;
    assign bus.aum      = w_up_pulse & ~w_dn_held & ~w_both_pulse;
    assign bus.dism     = w_dn_pulse & ~w_up_held & ~w_both_pulse;

endmodule

`default_nettype wire

// File: tb/tb_pulse_updown_cond.sv
// ============================================================================
// Module      : tb_pulse_updown_cond
// Description : Directed and randomized bench for pulse_updown_cond against a
//               run-length reference model; honours AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_updown_cond;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic clk;
    logic reset;
    pulse_updown_cond_if bus_if ();

    pulse_updown_cond #(
        .DEB_CYCLES    (DEB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of one button: pipe = synchronizer delay, ones/zeros = current
    // run lengths of the synchronized level, pressed = accepted level,
    // age = edges spent continuously held since entering the held condition.
    typedef struct packed {
        bit [1:0] pipe;
        int       ones;
        int       zeros;
        int       age;
        bit       pressed;
        bit       last_s;
        bit       pulse;
    } ch_model_t;

    ch_model_t m_up, m_dn;
    bit cur_up, cur_dn, cur_rst;
    bit exp_aum, exp_dism;
    int n_checks, n_pass;
    bit st_up[$], st_dn[$], st_rst[$];
    int aum_t[$], dism_t[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    function automatic ch_model_t ch_step(input ch_model_t m, input bit b, input bit rst);
        ch_model_t n;
        bit s, was_held;
        n = m;
        if (rst) begin
            n = '0;
            return n;
        end
        s        = m.pipe[1];
        was_held = m.pressed && m.last_s;
        n.pipe   = {m.pipe[0], b};
        n.pulse  = 1'b0;
        if (s) begin
            n.ones  = m.ones + 1;
            n.zeros = 0;
        end else begin
            n.zeros = m.zeros + 1;
            n.ones  = 0;
        end
        if (!m.pressed && n.ones == DEB + 1) begin
            n.pressed = 1'b1;
            n.pulse   = 1'b1;
        end else if (m.pressed && n.zeros == DEB + 1) begin
            n.pressed = 1'b0;
        end
        if (was_held && s) n.age = m.age + 1;
        else               n.age = 0;
`ifdef AUTO_REPEAT_EN
        if (was_held && s && (n.age == RD + 1 || (n.age > RD + 1 && (n.age - RD - 1) % RP == 0)))
            n.pulse = 1'b1;
`endif
        n.last_s = s;
        return n;
    endfunction

    // One clock: model the edge with the levels present on the pins, drive
    // the next levels, then compare outputs mid-cycle.
    task automatic tick(input bit up, input bit dn, input bit rst);
        bit dn_held, up_held;
        @(posedge clk);
        m_up     = ch_step(m_up, cur_up, cur_rst);
        m_dn     = ch_step(m_dn, cur_dn, cur_rst);
        up_held  = m_up.pressed && m_up.last_s;
        dn_held  = m_dn.pressed && m_dn.last_s;
        exp_aum  = m_up.pulse && !dn_held && !(m_up.pulse && m_dn.pulse);
        exp_dism = m_dn.pulse && !up_held && !(m_up.pulse && m_dn.pulse);
        #1;
        bus_if.btn_up   = up;
        bus_if.btn_down = dn;
        reset           = rst;
        cur_up  = up;
        cur_dn  = dn;
        cur_rst = rst;
        @(negedge clk);
        chk("aum", int'(bus_if.aum), int'(exp_aum));
        chk("dism", int'(bus_if.dism), int'(exp_dism));
    endtask

    task automatic push(input bit up, input bit dn, input bit rst, input int n);
        for (int i = 0; i < n; i++) begin
            st_up.push_back(up);
            st_dn.push_back(dn);
            st_rst.push_back(rst);
        end
    endtask

    task automatic play();
        aum_t.delete();
        dism_t.delete();
        for (int i = 0; i < st_up.size(); i++) begin
            tick(st_up[i], st_dn[i], st_rst[i]);
            if (bus_if.aum)  aum_t.push_back(i);
            if (bus_if.dism) dism_t.push_back(i);
        end
        st_up.delete();
        st_dn.delete();
        st_rst.delete();
    endtask

    function automatic int first_or_none(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    initial begin
        int exp_rep[$];
        int n_early, n_late;
        int up_hold, dn_hold;
        bit up_lvl, dn_lvl, rst_lvl;

        n_checks = 0;
        n_pass   = 0;
        m_up     = '0;
        m_dn     = '0;
        bus_if.btn_up   = 1'b0;
        bus_if.btn_down = 1'b0;
        reset    = 1'b1;
        cur_up   = 1'b0;
        cur_dn   = 1'b0;
        cur_rst  = 1'b1;

        // reset state
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
        chk("rst_aum", int'(bus_if.aum), 0);
        chk("rst_dism", int'(bus_if.dism), 0);
        push(0, 0, 0, 10);
        play();

        // short glitch
        push(1, 0, 0, 3);
        push(0, 0, 0, 20);
        play();
        chk("glitch_aum_cnt", aum_t.size(), 0);

        // single press
        push(1, 0, 0, 10);
        push(0, 0, 0, 25);
        play();
        chk("press_aum_cnt", aum_t.size(), 1);
        chk("press_aum_t", first_or_none(aum_t), 7);
        chk("press_dism_cnt", dism_t.size(), 0);

        // long hold on down
`ifdef AUTO_REPEAT_EN
        exp_rep = {7, 28, 36, 44};
`else
        exp_rep = {7};
`endif
        push(0, 1, 0, 50);
        push(0, 0, 0, 30);
        play();
        n_early = 0;
        n_late  = 0;
        foreach (dism_t[i]) begin
            if (dism_t[i] < 50)  n_early++;
            if (dism_t[i] >= 53) n_late++;
        end
        chk("hold_dism_cnt", n_early, exp_rep.size());
        foreach (exp_rep[i])
            chk("hold_dism_t", (i < dism_t.size()) ? dism_t[i] : -1, exp_rep[i]);
        chk("hold_dism_after_release", n_late, 0);
        chk("hold_aum_cnt", aum_t.size(), 0);

        // simultaneous press
        push(1, 1, 0, 10);
        push(0, 0, 0, 25);
        play();
        chk("both_aum_cnt", aum_t.size(), 0);
        chk("both_dism_cnt", dism_t.size(), 0);

        // reset mid-press
        push(1, 0, 0, 5);
        push(1, 0, 1, 1);
        push(1, 0, 0, 10);
        push(0, 0, 0, 25);
        play();
        chk("rstpress_aum_cnt", aum_t.size(), 1);
        chk("rstpress_aum_t", first_or_none(aum_t), 13);

        // bounce during release
        push(1, 0, 0, 12);
        push(0, 0, 0, 2);
        push(1, 0, 0, 2);
        push(0, 0, 0, 3);
        push(1, 0, 0, 1);
        push(0, 0, 0, 25);
        play();
        chk("bounce_aum_cnt", aum_t.size(), 1);
        chk("bounce_aum_t", first_or_none(aum_t), 7);

        // randomized levels and occasional reset
        up_hold = 0;
        dn_hold = 0;
        up_lvl  = 1'b0;
        dn_lvl  = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (up_hold == 0) begin
                up_lvl  = ~up_lvl;
                up_hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                      : int'($urandom_range(1, 8));
            end
            if (dn_hold == 0) begin
                dn_lvl  = ~dn_lvl;
                dn_hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                      : int'($urandom_range(1, 8));
            end
            rst_lvl = ($urandom_range(0, 299) == 0);
            tick(up_lvl, dn_lvl, rst_lvl);
            up_hold--;
            dn_hold--;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
